// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding data-memory access with byte enables, load extension,
// pass-through of non-memory results, and misaligned/timeout exception reporting.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [1:0]  in_mem_size,
    input  logic        in_mem_sign,
    input  logic [31:0] in_address,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd_id,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd_id,
    output logic        out_exception,
    output logic [1:0]  out_exc_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tmo_cnt;
    logic          ld_sign;
    logic [1:0]    ld_size, ld_off;
    logic [4:0]    rd_q;
    logic          accept, is_mem, misaligned, done, timeout;
    logic [3:0]    be_nx;
    logic [31:0]   wdata_nx, shifted, load_data;

    assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_mem_read || in_mem_write;
    assign dmem_req = (state == REQ);
    assign done     = (state == WAIT) && dmem_rvalid;
    // A response landing on the final counted cycle still completes the access.
    assign timeout  = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES)) && !done;

    always_comb begin
        misaligned = 1'b0;
        be_nx      = 4'b1111;
        wdata_nx   = in_store_data;
        case (in_mem_size)
            2'b00: begin
                be_nx    = 4'b0001 << in_address[1:0];
                wdata_nx = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                misaligned = in_address[0];
                be_nx      = 4'b0011 << in_address[1:0];
                wdata_nx   = {2{in_store_data[15:0]}};
            end
            2'b10:   misaligned = (in_address[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        shifted   = dmem_rdata >> {ld_off, 3'b000};
        load_data = shifted;
        case (ld_size)
            2'b00:   load_data = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && is_mem && !misaligned) state_nx = REQ;
            REQ:  if (timeout) state_nx = IDLE;
                  else if (dmem_gnt) state_nx = WAIT;
            WAIT: if (done || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt       <= '0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            ld_sign       <= 1'b0;
            ld_size       <= '0;
            ld_off        <= '0;
            rd_q          <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_rd_id     <= '0;
            out_exception <= 1'b0;
            out_exc_cause <= '0;
        end else begin
            if (accept && is_mem && !misaligned) begin
                tmo_cnt    <= CW'(1);
                dmem_we    <= in_mem_write;
                dmem_addr  <= {in_address[31:2], 2'b00};
                dmem_be    <= be_nx;
                dmem_wdata <= wdata_nx;
                ld_sign    <= in_mem_sign;
                ld_size    <= in_mem_size;
                ld_off     <= in_address[1:0];
                rd_q       <= in_rd_id;
            end else if (state != IDLE && !done && !timeout) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end else if (state != IDLE) begin
                tmo_cnt <= '0;
            end

            if (accept && (!is_mem || misaligned)) begin
                out_valid     <= 1'b1;
                out_data      <= is_mem ? 32'h0 : in_address;
                out_rd_id     <= in_rd_id;
                out_exception <= is_mem;
                out_exc_cause <= !is_mem ? 2'b00 : (in_mem_write ? 2'b10 : 2'b01);
            end else if (done) begin
                out_valid     <= 1'b1;
                out_data      <= dmem_we ? 32'h0 : load_data;
                out_rd_id     <= rd_q;
                out_exception <= 1'b0;
                out_exc_cause <= 2'b00;
            end else if (timeout) begin
                out_valid     <= 1'b1;
                out_data      <= 32'h0;
                out_rd_id     <= rd_q;
                out_exception <= 1'b1;
                out_exc_cause <= 2'b11;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout, backpressure and reset sequences.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_mem_read, in_mem_write, in_mem_sign;
    logic [1:0]  in_mem_size;
    logic [31:0] in_address, in_store_data;
    logic [4:0]  in_rd_id;
    logic        out_valid, out_ready, out_exception;
    logic [31:0] out_data;
    logic [4:0]  out_rd_id;
    logic [1:0]  out_exc_cause;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_size(in_mem_size), .in_mem_sign(in_mem_sign),
        .in_address(in_address), .in_store_data(in_store_data), .in_rd_id(in_rd_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd_id(out_rd_id), .out_exception(out_exception), .out_exc_cause(out_exc_cause),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en, wr_en, sign;
        logic [1:0]  size;
        logic [31:0] addr, sdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        bus;
        logic [31:0] daddr;
        logic [3:0]  be;
        logic [31:0] wdata, data;
        logic        exc;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic r, logic w, logic [1:0] sz, logic sg, logic [31:0] a,
                                logic [31:0] sd, logic [4:0] rd, logic [31:0] rdat, logic bus,
                                logic [31:0] da, logic [3:0] be, logic [31:0] wd,
                                logic [31:0] d, logic exc, logic [1:0] c);
        vec_t v;
        v.rd_en = r; v.wr_en = w; v.size = sz; v.sign = sg; v.addr = a; v.sdata = sd;
        v.rd = rd; v.rdata = rdat; v.bus = bus; v.daddr = da; v.be = be; v.wdata = wd;
        v.data = d; v.exc = exc; v.cause = c;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(logic r, logic w, logic [1:0] sz, logic sg, logic [31:0] a,
                            logic [31:0] sd, logic [4:0] rd);
        in_valid = 1'b1; in_mem_read = r; in_mem_write = w; in_mem_size = sz;
        in_mem_sign = sg; in_address = a; in_store_data = sd; in_rd_id = rd;
    endtask

    // Zero-wait bus: accept T, req+gnt T+1, rvalid T+2, result T+3.
    task automatic apply(vec_t v);
        @(posedge clk) #1;
        drive_op(v.rd_en, v.wr_en, v.size, v.sign, v.addr, v.sdata, v.rd);
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        if (v.bus) begin
            dmem_gnt = 1'b1;
            @(negedge clk);
            chk("req", 32'(dmem_req), 32'd1);
            chk("daddr", dmem_addr, v.daddr);
            chk("be", 32'(dmem_be), 32'(v.be));
            chk("we", 32'(dmem_we), 32'(v.wr_en));
            if (v.wr_en) chk("wdata", dmem_wdata, v.wdata);
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk) #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
            @(negedge clk);
            chk("req_wait", 32'(dmem_req), 32'd0);
            chk("valid_wait", 32'(out_valid), 32'd0);
            @(posedge clk) #1;
            dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        end
        @(negedge clk);
        if (!v.bus) chk("no_req", 32'(dmem_req), 32'd0);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_data", out_data, v.data);
        chk("out_rd_id", 32'(out_rd_id), 32'(v.rd));
        chk("out_exc", 32'(out_exception), 32'(v.exc));
        chk("out_cause", 32'(out_exc_cause), 32'(v.cause));
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 2'b10, 0, 32'h1234_5678, 32'h0, 5'd5, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 0, 2'b00);
        vecs[1]  = mk(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 5'd1, 32'h80AA_BBCC, 1, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, 2'b00);
        vecs[2]  = mk(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 5'd2, 32'h80AA_BBCC, 1, 32'h100, 4'b1000, 32'h0, 32'h0000_0080, 0, 2'b00);
        vecs[3]  = mk(0, 1, 2'b01, 0, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 32'h0, 1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 2'b00);
        vecs[4]  = mk(1, 0, 2'b10, 0, 32'h0000_0003, 32'h0, 5'd4, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 2'b01);
        vecs[5]  = mk(0, 1, 2'b01, 0, 32'h0000_0005, 32'h1111_2222, 5'd6, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 2'b10);
        vecs[6]  = mk(1, 0, 2'b10, 1, 32'h0000_0400, 32'h0, 5'd7, 32'hCAFE_F00D, 1, 32'h400, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, 2'b00);
        vecs[7]  = mk(1, 0, 2'b01, 1, 32'h0000_0102, 32'h0, 5'd8, 32'h8001_1234, 1, 32'h100, 4'b1100, 32'h0, 32'hFFFF_8001, 0, 2'b00);
        vecs[8]  = mk(1, 0, 2'b01, 0, 32'h0000_0100, 32'h0, 5'd9, 32'h1234_ABCD, 1, 32'h100, 4'b0011, 32'h0, 32'h0000_ABCD, 0, 2'b00);
        vecs[9]  = mk(1, 0, 2'b11, 0, 32'h0000_0000, 32'h0, 5'd10, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 2'b01);
        vecs[10] = mk(1, 1, 2'b00, 0, 32'h0000_0001, 32'h0000_00A5, 5'd11, 32'h0, 1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0, 2'b00);

        reset = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_mem_size = 2'b00; in_mem_sign = 1'b0; in_address = '0; in_store_data = '0;
        in_rd_id = '0; out_ready = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_data", out_data, 32'd0);
        @(posedge clk) #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) apply(vecs[i]);

        // Bus timeout: gnt never comes; 4 REQ cycles then cause 11, late rvalid ignored.
        @(posedge clk) #1;
        drive_op(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0, 5'd12);
        @(posedge clk) #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tmo_req", 32'(dmem_req), 32'd1);
            chk("tmo_busy", 32'(out_valid), 32'd0);
            @(posedge clk) #1;
        end
        @(negedge clk);
        chk("tmo_req_off", 32'(dmem_req), 32'd0);
        chk("tmo_valid", 32'(out_valid), 32'd1);
        chk("tmo_exc", 32'(out_exception), 32'd1);
        chk("tmo_cause", 32'(out_exc_cause), 32'd3);
        chk("tmo_rd", 32'(out_rd_id), 32'd12);
        chk("tmo_data", out_data, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        @(posedge clk) #1;
        @(negedge clk);
        chk("late_rvalid_1", 32'(out_valid), 32'd0);
        @(posedge clk) #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_2", 32'(out_valid), 32'd0);

        // Backpressure: result held 3 cycles, then drain and accept in the same cycle.
        @(posedge clk) #1;
        out_ready = 1'b0;
        drive_op(0, 0, 2'b10, 0, 32'hA5A5_0001, 32'h0, 5'd7);
        @(posedge clk) #1;
        drive_op(0, 0, 2'b10, 0, 32'h0BAD_F00D, 32'h0, 5'd14);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'hA5A5_0001);
            chk("bp_rd", 32'(out_rd_id), 32'd7);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk) #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd1);
        chk("drain_data", out_data, 32'h0BAD_F00D);
        chk("drain_rd", 32'(out_rd_id), 32'd14);

        // Reset during WAIT aborts the access without a result.
        @(posedge clk) #1;
        drive_op(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0, 5'd15);
        @(posedge clk) #1;
        in_valid = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk) #1;
        dmem_gnt = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_valid", 32'(out_valid), 32'd0);
        chk("rstw_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk) #1;
        reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rstw_stale_req", 32'(dmem_req), 32'd0);
        @(posedge clk) #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rstw_stale_valid", 32'(out_valid), 32'd0);
        apply(vecs[1]);

        @(posedge clk) #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the pipeline, directly downstream of decode/ALU. Consumes the decoded memory controls (`mem_read`, `mem_write`, `mem_size`, `mem_sign`) and the ALU result as the effective address. Drives a single-outstanding, word-wide data-memory bus with byte enables, then sign- or zero-extends load data. Non-memory instructions pass through with one cycle of latency; misaligned accesses and bus timeouts are flagged as exceptions.

## Interface
- TIMEOUT_CYCLES, 255, maximum cycles from entering REQ until `dmem_rvalid` before abort (>=2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  unit can accept; transfer when `in_valid && in_ready`
- in_mem_read  in  1  load
- in_mem_write  in  1  store; wins if both set
- in_mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- in_mem_sign  in  1  1 = sign-extend load, 0 = zero-extend
- in_address  in  32  ALU result / effective address
- in_store_data  in  32  rs2 value
- in_rd_id  in  5  destination register
- out_valid  out  1  result register full
- out_ready  in  1  downstream accepts
- out_data  out  32  load data, pass-through ALU result, or 0 for stores/exceptions
- out_rd_id  out  5  captured `in_rd_id`
- out_exception  out  1  exception on this result
- out_exc_cause  out  2  00 none, 01 misaligned load, 10 misaligned store, 11 bus timeout
- dmem_req  out  1  request; held until grant
- dmem_we  out  1  write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response, for both loads and stores
- dmem_rdata  in  32  load word

## Operation
- FSM states: IDLE, REQ, WAIT.
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`; 0 while `reset` is high.
- On accept in IDLE:
  - Non-memory op: capture `in_address` into `out_data`; `out_valid` goes high.
  - Misaligned op: report exception with cause 01/10 and `out_data = 0`; no bus request. Misaligned means half with `addr[0]`, word with `addr[1:0] != 0`, or size 11.
  - Aligned op: register `dmem_addr`, `dmem_be`, `dmem_wdata`, `dmem_we` and the load controls, then go to REQ.
- Byte enables: byte `4'b0001 << addr[1:0]`; half `4'b0011 << addr[1:0]`; word `4'b1111`.
- Store data: byte replicated ×4, half ×2, word as-is.
- REQ: `dmem_req = 1`; address, enables and data stay stable. Go to WAIT when `dmem_gnt` is high.
- WAIT: on `dmem_rvalid`, write the result register and go to IDLE.
  - Load result: `shifted = dmem_rdata >> (8*addr[1:0])`, take the low 8 or 16 bits, extend per `mem_sign`.
  - Store result: `out_data = 0`.
- Timeout counter:
  - Loads 1 on entry to REQ and increments each cycle in REQ/WAIT.
  - When it equals TIMEOUT_CYCLES with no `rvalid` that cycle: abort to IDLE with cause 11.
  - If `rvalid` arrives in the same cycle, `rvalid` wins.
  - Any `dmem_rvalid` or `dmem_gnt` seen in IDLE is ignored.
- Result register holds stable while `out_valid && !out_ready`.

## Timing
- Reset: all outputs 0, state IDLE, counter 0. An asserted reset drops `dmem_req` immediately and discards the in-flight access; no result is produced.
- Non-memory or misaligned: accept in cycle T, `out_valid` in T+1.
- Aligned access with zero-wait bus: accept T, `dmem_req` T+1 with `gnt`, `rvalid` T+2, `out_valid` T+3.
- At most one instruction in flight; `in_ready` is 0 in REQ/WAIT.
- Output drained and new accept may occur in the same cycle (`out_valid && out_ready && in_valid`).

## Test plan
- Pass-through:
  - Stimulus: non-memory op, `in_address = 0x1234_5678`, `rd = 5`.
  - Required: `out_valid` next cycle, `out_data = 0x12345678`, `out_rd_id = 5`, no exception.
- Signed byte load:
  - Stimulus: `addr = 0x103`, byte, signed; `rdata = 0x80AA_BBCC`.
  - Required: `dmem_addr = 0x100`, `be = 1000`, `out_data = 0xFFFF_FF80`. Repeat unsigned: `0x0000_0080`.
- Half store:
  - Stimulus: `addr = 0x202`, data `0xDEAD_BEEF`.
  - Required: `be = 1100`, `wdata = 0xBEEF_BEEF`, `we = 1`, `out_data = 0`.
- Misaligned access:
  - Stimulus: word load at `0x3`.
  - Required: no `dmem_req`, `out_exception = 1`, cause 01, `out_valid` at T+1. Half store at `0x5` gives cause 10.
- Bus timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, `gnt` never asserted.
  - Required: cause 11 after 4 REQ cycles. A late `rvalid` afterwards is ignored.
- Backpressure and reset:
  - Stimulus: `out_ready = 0` for 3 cycles.
  - Required: output stable and `in_ready = 0`.
  - Stimulus: `reset` asserted while in WAIT.
  - Required: `dmem_req`/`out_valid` go to 0 immediately; the next load after reset completes normally.
